// File: rtl/ca_frame_writer_pkg.sv
// Shared constants and state encoding for the cellular-automaton frame writer.
// Defaults describe a 1280x1024 frame of 20-pixel words.
package ca_pkg;

  localparam int WORD_W        = 20;
  localparam int ROW_WORDS     = 64;
  localparam int ROWS          = 1024;
  localparam int SEED_ADDR     = 32;
  localparam int LAST_ROW_BASE = 65472;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COPY_RD,
    COPY_WR,
    PRIME,
    FETCH,
    STORE,
    FIN
  } state_t;

endpackage

// File: rtl/ca_frame_writer_if.sv
// Frame-buffer port A: one word address, write data/enable, and read data
// that is valid one cycle after a read address is presented.
interface ca_frame_writer_if;
  import ca_pkg::*;

  logic [15:0]       address_a;
  logic [WORD_W-1:0] data_a;
  logic              wren_a;
  logic [WORD_W-1:0] q_a;

  modport master (
    output address_a,
    output data_a,
    output wren_a,
    input  q_a
  );

  modport slave (
    input  address_a,
    input  data_a,
    input  wren_a,
    output q_a
  );

endinterface

// File: rtl/ca_frame_writer_rule_word.sv
// Applies an elementary-CA rule to one 20-pixel word; prev and next
// supply the neighbours of the word's edge pixels.
module ca_rule_word
  import ca_pkg::*;
(
  input  logic [WORD_W-1:0] prev,
  input  logic [WORD_W-1:0] cur,
  input  logic [WORD_W-1:0] next,
  input  logic [7:0]        rule,
  output logic [WORD_W-1:0] word
);

  // ext[i] is pixel i-1, so pixel i sees {ext[i], ext[i+1], ext[i+2]}
  logic [WORD_W+1:0] ext;

  assign ext = {next[0], cur, prev[WORD_W-1]};

  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    assign word[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
  end

endmodule

// File: rtl/ca_frame_writer.sv
// Clears/seeds the frame buffer, or copies the last row to row 0 and
// regenerates every following row from the row above it.
module ca_frame_writer #(
  parameter int WORD_W    = ca_pkg::WORD_W,
  parameter int ROW_WORDS = ca_pkg::ROW_WORDS,
  parameter int ROWS      = ca_pkg::ROWS
) (
  input  logic                clk108,
  input  logic                reset,
  input  logic                ready_sig,
  input  logic                seed,
  input  logic [7:0]          rule,
  ca_frame_writer_if.master   mem,
  output logic                busy,
  output logic                done
);
  import ca_pkg::*;

  localparam int SH = $clog2(ROW_WORDS);
  localparam logic [15:0] LAST_W    = 16'(ROW_WORDS - 1);
  localparam logic [15:0] LAST_ROW  = 16'(ROWS - 1);
  localparam logic [15:0] LAST_BASE = 16'((ROWS - 1) * ROW_WORDS);
  localparam logic [15:0] SEED_W    = 16'(ROW_WORDS / 2);
  localparam logic [15:0] MEM_LAST  = 16'(ROWS * ROW_WORDS - 1);

  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] row, row_n;
  logic        ph, ph_n;
  logic [WORD_W-1:0] prev, prev_n;
  logic [WORD_W-1:0] cur, cur_n;
  logic [7:0]  rule_q, rule_n;

  logic [15:0] addr;
  logic [WORD_W-1:0] wdata;
  logic        wr;
  logic [WORD_W-1:0] nxt;
  logic [WORD_W-1:0] word;
  logic [15:0] row_m1;
  logic [15:0] base_cur;
  logic [15:0] base_prv;

  assign row_m1   = row - 16'd1;
  assign base_cur = row << SH;
  assign base_prv = row_m1 << SH;

  // The word after the last one in a row is off the edge, so it reads as 0
  assign nxt = (state == STORE && cnt != LAST_W) ? mem.q_a : '0;

  ca_rule_word u_rule (
    .prev (prev),
    .cur  (cur),
    .next (nxt),
    .rule (rule_q),
    .word (word)
  );

  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      row    <= '0;
      ph     <= 1'b0;
      prev   <= '0;
      cur    <= '0;
      rule_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      row    <= row_n;
      ph     <= ph_n;
      prev   <= prev_n;
      cur    <= cur_n;
      rule_q <= rule_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    row_n   = row;
    ph_n    = ph;
    prev_n  = prev;
    cur_n   = cur;
    rule_n  = rule_q;
    addr    = '0;
    wdata   = '0;
    wr      = 1'b0;
    done    = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (seed) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else if (ready_sig) begin
          state_n = COPY_RD;
          cnt_n   = '0;
          rule_n  = rule;
        end
      end
      CLEAR: begin
        addr  = cnt;
        wdata = (cnt == SEED_W) ? WORD_W'(1) : '0;
        wr    = 1'b1;
        cnt_n = cnt + 16'd1;
        if (cnt == MEM_LAST) state_n = FIN;
      end
      COPY_RD: begin
        addr    = LAST_BASE + cnt;
        state_n = COPY_WR;
      end
      COPY_WR: begin
        addr  = cnt;
        wdata = mem.q_a;
        wr    = 1'b1;
        cnt_n = cnt + 16'd1;
        state_n = COPY_RD;
        if (cnt == LAST_W) begin
          state_n = PRIME;
          cnt_n   = '0;
          row_n   = 16'd1;
          ph_n    = 1'b0;
        end
      end
      PRIME: begin
        // first cycle issues the read, second captures it
        addr = base_prv;
        if (!ph) begin
          ph_n = 1'b1;
        end else begin
          ph_n    = 1'b0;
          cur_n   = mem.q_a;
          prev_n  = '0;
          cnt_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (cnt != LAST_W) addr = base_prv + cnt + 16'd1;
        state_n = STORE;
      end
      STORE: begin
        addr   = base_cur + cnt;
        wdata  = word;
        wr     = 1'b1;
        prev_n = cur;
        cur_n  = nxt;
        if (cnt == LAST_W) begin
          cnt_n = '0;
          if (row == LAST_ROW) begin
            state_n = FIN;
          end else begin
            row_n   = row + 16'd1;
            state_n = PRIME;
          end
        end else begin
          cnt_n   = cnt + 16'd1;
          state_n = FETCH;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign mem.address_a = addr;
  assign mem.data_a    = wdata;
  assign mem.wren_a    = wr;

endmodule

// File: tb/tb_ca_frame_writer.sv
// Scoreboarded bench: a pixel-level model queues expected writes, a
// negedge monitor pops and compares every frame-buffer write.
module tb_ca_frame_writer;

  localparam int RW    = 64;
  localparam int NR    = 16;
  localparam int NW    = RW * NR;
  localparam int PIX   = RW * 20;
  localparam int LASTB = (NR - 1) * RW;
  localparam int PASS_N = 128 + (NR - 1) * 130 + 1;

  typedef struct packed {
    logic [15:0] a;
    logic [19:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready_sig = 1'b0;
  logic       seed = 1'b0;
  logic [7:0] rule = 8'd0;
  logic       busy;
  logic       done;

  ca_frame_writer_if mif ();

  ca_frame_writer #(
    .WORD_W    (20),
    .ROW_WORDS (RW),
    .ROWS      (NR)
  ) dut (
    .clk108    (clk),
    .reset     (rst),
    .ready_sig (ready_sig),
    .seed      (seed),
    .rule      (rule),
    .mem       (mif),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [19:0] mem [NW];
  logic [19:0] ref_mem [NW];
  logic [19:0] old_row [RW];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0;
  logic [19:0] poke_d = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_a[9:0]] <= poke_d;
    else if (mif.wren_a) mem[mif.address_a[9:0]] <= mif.data_a;
    mif.q_a <= mem[mif.address_a[9:0]];
  end

  wr_t exp_q[$];
  wr_t e;
  int  vecs = 0;
  int  errs = 0;

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mif.wren_a) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: got addr %h data %h, none expected",
                 mif.address_a, mif.data_a);
      end else begin
        e = exp_q.pop_front();
        check("write", {4'h0, mif.address_a, mif.data_a}, {4'h0, e.a, e.d});
      end
    end
  end

  task automatic push(input int a, input logic [19:0] d);
    wr_t w;
    w.a = 16'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic model_clear();
    for (int a = 0; a < NW; a++) begin
      ref_mem[a] = (a == 32) ? 20'h00001 : 20'h00000;
      push(a, ref_mem[a]);
    end
  endtask

  task automatic model_pass(input logic [7:0] r);
    logic px [PIX];
    logic nx [PIX];
    logic l, rr;
    logic [19:0] d;
    for (int i = 0; i < RW; i++) begin
      ref_mem[i] = ref_mem[LASTB + i];
      push(i, ref_mem[i]);
    end
    for (int row = 1; row < NR; row++) begin
      for (int p = 0; p < PIX; p++)
        px[p] = ref_mem[(row - 1) * RW + p / 20][p % 20];
      for (int p = 0; p < PIX; p++) begin
        l  = (p == 0) ? 1'b0 : px[p - 1];
        rr = (p == PIX - 1) ? 1'b0 : px[p + 1];
        nx[p] = r[{l, px[p], rr}];
      end
      for (int w = 0; w < RW; w++) begin
        for (int b = 0; b < 20; b++) d[b] = nx[w * 20 + b];
        ref_mem[row * RW + w] = d;
        push(row * RW + w, d);
      end
    end
  endtask

  task automatic poke(input int a, input logic [19:0] d);
    @(negedge clk);
    poke_a = 16'(a);
    poke_d = d;
    poke_en = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run(input string name, input bit s, input bit rd,
                     input logic [7:0] r, input int exp_n);
    int n = 0;
    bit got = 0;
    @(negedge clk);
    seed = s;
    ready_sig = rd;
    rule = r;
    while (n < exp_n + 20 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        seed = 1'b0;
        ready_sig = 1'b0;
        rule = ~r;
      end
      if (n == 3) begin
        seed = 1'b1;
        ready_sig = 1'b1;
      end
      if (n == 4) begin
        seed = 1'b0;
        ready_sig = 1'b0;
      end
      if (done) got = 1;
    end
    if (!got) begin
      vecs++;
      errs++;
      $display("FAIL %s_timeout: no done after %0d cycles, required %0d",
               name, n, exp_n);
    end else begin
      check({name, "_cycles"}, 40'(n), 40'(exp_n));
    end
    @(posedge clk);
    #1 check({name, "_done_pulse"}, {38'h0, done, busy}, 40'h0);
    repeat (3) @(posedge clk);
    #1 check({name, "_drain"}, 40'(exp_q.size()), 40'h0);
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1 check("reset_out",
             {1'b0, mif.address_a, mif.data_a, mif.wren_a, busy, done},
             40'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("idle_busy", {38'h0, busy, done}, 40'h0);

    model_clear();
    run("seed", 1'b1, 1'b1, 8'd30, NW + 1);
    check("seed_w32", 40'(mem[32]), 40'h00001);
    check("seed_w33", 40'(mem[33]), 40'h00000);

    poke(LASTB + 32, 20'h00001);
    model_pass(8'd90);
    run("r90", 1'b0, 1'b1, 8'd90, PASS_N);
    check("r90_row0", 40'(mem[32]), 40'h00001);
    check("r90_r1w31", 40'(mem[RW + 31]), 40'h80000);
    check("r90_r1w32", 40'(mem[RW + 32]), 40'h00002);
    check("r90_r2w31", 40'(mem[2 * RW + 31]), 40'h40000);
    check("r90_r2w32", 40'(mem[2 * RW + 32]), 40'h00004);

    for (int i = 0; i < RW; i++) poke(LASTB + i, 20'($urandom));
    model_pass(8'd204);
    run("r204", 1'b0, 1'b1, 8'd204, PASS_N);
    bad = 0;
    for (int a = RW; a < NW; a++)
      if (mem[a] !== mem[a % RW]) bad++;
    check("r204_rows", 40'(bad), 40'h0);

    for (int i = 0; i < RW; i++) old_row[i] = mem[LASTB + i];
    model_pass(8'd0);
    run("r0", 1'b0, 1'b1, 8'd0, PASS_N);
    bad = 0;
    for (int a = RW; a < NW; a++)
      if (mem[a] !== 20'h0) bad++;
    for (int i = 0; i < RW; i++)
      if (mem[i] !== old_row[i]) bad++;
    check("r0_rows", 40'(bad), 40'h0);

    poke(LASTB + 63, 20'h80001);
    poke(LASTB + 0, 20'h00001);
    model_pass(8'd170);
    run("r170", 1'b0, 1'b1, 8'd170, PASS_N);
    check("r170_r1w63", 40'(mem[RW + 63]), 40'h40000);
    check("r170_r1w62", 40'(mem[RW + 62]), 40'h80000);
    check("r170_r1w0", 40'(mem[RW]), 40'h00000);
    check("r170_r2w63", 40'(mem[2 * RW + 63]), 40'h20000);

    model_pass(8'd90);
    @(negedge clk);
    ready_sig = 1'b1;
    rule = 8'd90;
    @(negedge clk);
    ready_sig = 1'b0;
    repeat (128 + 7 * 130 + 40) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("abort_out",
             {1'b0, mif.address_a, mif.data_a, mif.wren_a, busy, done},
             40'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_idle", {38'h0, busy, done}, 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ca_frame_writer.md
CA_FRAME_WRITER -- requirements
Module: ca_frame_writer

Interface
REQ-001 Parameter WORD_W, 20, pixels per frame-buffer word (bit 0 = leftmost pixel).
REQ-002 Parameter ROW_WORDS, 64, words per 1280-pixel row.
REQ-003 Parameter ROWS, 1024, rows per frame.
REQ-004 clk108  in  1  single clock, 108 MHz pixel clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ready_sig  in  1  end-of-frame pulse from display scanner; requests one generation pass.
REQ-007 seed  in  1  pulse; requests frame clear plus single-pixel seed.
REQ-008 rule  in  8  Wolfram elementary-CA rule number.
REQ-009 address_a  out  16  frame-buffer port A word address.
REQ-010 data_a  out  20  frame-buffer port A write data.
REQ-011 wren_a  out  1  port A write enable.
REQ-012 q_a  in  20  port A read data, valid one cycle after address_a presented with wren_a=0.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse on completion of a seed or generation pass.

Function
REQ-015 States SHALL be IDLE, CLEAR, COPY_RD, COPY_WR, PRIME, FETCH, STORE, FIN.
REQ-016 IDLE: seed=1 -> CLEAR; else ready_sig=1 -> COPY_RD; seed SHALL win when both high same cycle.
REQ-017 seed and ready_sig SHALL be ignored while busy=1 (no queuing).
REQ-018 rule SHALL be latched on the IDLE->COPY_RD transition and held for the whole pass.
REQ-019 CLEAR: write addresses 0..65535, one per cycle; data 20'h00001 at address 32 (pixel 640), 0 elsewhere; then FIN.
REQ-020 COPY_RD/COPY_WR: for i=0..63, read address 65472+i, write captured q_a to address i; two cycles per word.
REQ-021 Generation: for rows r=1..1023, new row r computed from row r-1 (row base = r<<6, 16-bit arithmetic).
REQ-022 PRIME: read word 0 of row r-1, latch into cur; prev cleared to 0.
REQ-023 FETCH: present read of word w+1 of row r-1, wren_a=0; for w=63 no read, next treated as 0.
REQ-024 STORE: next=q_a (or 0 at w=63); write word w of row r = rule applied to {prev,cur,next}; then prev<=cur, cur<=next.
REQ-025 New bit i = rule[{left,centre,right}], left = pixel i-1, right = pixel i+1; bit 0 left = prev[19], bit 19 right = next[0].
REQ-026 Row boundary SHALL be null: pixels left of pixel 0 and right of pixel 1279 are 0.
REQ-027 After STORE of word 63 of row 1023 -> FIN; FIN asserts done for one cycle, then IDLE.
REQ-028 Throughput: COPY 128 cycles plus 130 cycles per row; a full pass SHALL complete in <= 133,250 cycles, ahead of the display reaching each row.
REQ-029 wren_a SHALL be high only in CLEAR, COPY_WR, STORE; data_a 0 when wren_a=0.

Reset
REQ-030 Reset SHALL force IDLE, address_a=0, data_a=0, wren_a=0, busy=0, done=0, prev=cur=0, latched rule=0.
REQ-031 Reset mid-pass SHALL abort immediately with no further writes; memory contents left as-is.

Structure
REQ-032 Package ca_pkg SHALL hold WORD_W, ROW_WORDS, ROWS, SEED_ADDR=32, LAST_ROW_BASE=65472 and the state enum.
REQ-033 Sub-module ca_rule_word SHALL be the combinational 20-bit rule applicator (inputs prev, cur, next, rule; output word).

Verification
REQ-034 seed pulse from reset -> 65536 writes, address 32 data 20'h00001, all others 0, done after 65536+1 cycles.
REQ-035 seed then ready_sig, rule=90 -> row 1 word 31 = 20'h80000, word 32 = 20'h00002 (Sierpinski spread).
REQ-036 rule=204 (identity), random row 1023 -> after pass every row equals copied row 0.
REQ-037 rule=0 -> rows 1..1023 all zero; row 0 equals prior row 1023.
REQ-038 Row 1 word 63 bit 19 set, rule=170 (shift from right) -> word 63 bit 19 of row 2 equals 0 (null edge).
REQ-039 ready_sig and seed in same IDLE cycle -> CLEAR; ready_sig during busy ignored; reset at row 500 -> wren_a=0 same cycle, busy=0.
